settings_readback: RTL
======================

SETTINGS_READBACK -- requirements
Module: settings_readback

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port POR, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port BACT, input, 1 bit: bus access active.
REQ-004 SHALL have port SetCSRD, input, 1 bit: settings-register read select.
REQ-005 SHALL have port A1, input, 1 bit: word select; 0 selects the settings word, 1 selects the read-count word.
REQ-006 SHALL have ports SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd and SlowClockGate, input, 1 bit each: current settings flags.
REQ-007 SHALL have port SlowTimeout, input, 4 bits: current timeout setting.
REQ-008 SHALL have port Dout, output, 16 bits: readback data.
REQ-009 SHALL have port DoutOE, output, 1 bit: data output enable.
REQ-010 SHALL have port RdAck, output, 1 bit: read acknowledge.

Function
REQ-011 SHALL register the request as RdReq <= BACT && SetCSRD each cycle.
REQ-012 SHALL implement the FSM states IDLE, CAPTURE, DRIVE and HOLD.
REQ-013 IDLE SHALL move to CAPTURE on the first cycle in which RdReq is sampled high.
REQ-014 CAPTURE SHALL move to IDLE if BACT is sampled low, with no snapshot, no count change and no flag change (aborted read).
REQ-015 CAPTURE SHALL otherwise latch the Dout snapshot and move to DRIVE.
REQ-016 DRIVE SHALL move to HOLD after one cycle.
REQ-017 HOLD SHALL remain in HOLD while BACT is high and SHALL move to IDLE on the first cycle BACT is sampled low.
REQ-018 DoutOE SHALL be high exactly in DRIVE and HOLD.
REQ-019 RdAck SHALL be high exactly in HOLD.
REQ-020 Latency: RdReq high at edge n -> DoutOE high after edge n+2 -> RdAck high after edge n+3.
REQ-021 Release: BACT sampled low at edge m in HOLD -> DoutOE and RdAck low after edge m.
REQ-022 Dout SHALL be registered and SHALL hold the snapshot while DoutOE is high; Dout SHALL be 0 whenever DoutOE is low.
REQ-023 Word 0 format: [15:12]=4'hA (ID), [11:8]=SlowTimeout, [7]=SlowIACK, [6]=SlowVIA, [5]=SlowIWM, [4]=SlowSCC, [3]=SlowSCSI, [2]=SlowSnd, [1]=SlowClockGate, [0]=Changed.
REQ-024 Word 1 format: [15:0]=RdCount, the value before any increment caused by the current read.
REQ-025 A1 SHALL be sampled only in CAPTURE; changes to A1 afterward SHALL not affect Dout.
REQ-026 SHALL keep an 11-bit Prev register of {SlowTimeout, the 7 flags}, updated every cycle.
REQ-027 Changed SHALL be set when the current settings differ from Prev.
REQ-028 Changed SHALL be cleared on a CAPTURE->DRIVE transition with A1=0.
REQ-029 If a set condition and a clear occur in the same cycle, set SHALL win.
REQ-030 RdCount SHALL be 16 bits, SHALL increment by 1 on every CAPTURE->DRIVE transition of either word, and SHALL wrap 16'hFFFF->16'h0000.
REQ-031 A new request SHALL not be recognised until the FSM has returned to IDLE.
REQ-032 A request whose RdReq is still high on the IDLE-return cycle SHALL start a new read only once it is sampled high in IDLE.

Reset
REQ-033 While POR is high, the block SHALL force: state=IDLE, Dout=16'h0000, DoutOE=0, RdAck=0, RdReq=0, RdCount=0, Changed=0, Prev=11'h07F (timeout 0, all flags 1).
REQ-034 POR asserted mid-read SHALL immediately drop DoutOE and RdAck, with no count increment completed.
REQ-035 After POR deasserts, the block SHALL accept a new request normally.

Verification
REQ-036 Bench SHALL cover: POR, then word-0 read with defaults (timeout 0, flags 1) -> Dout=16'hA0FE, DoutOE after edge n+2, RdAck after edge n+3, release one edge after BACT low.
REQ-037 Bench SHALL cover: SlowTimeout changed to 4'h5 with SlowSnd=0, then word-0 read -> Dout=16'hA5FB; an immediate second read -> 16'hA5FA.
REQ-038 Bench SHALL cover: three completed reads, then word-1 read -> Dout=16'h0003; after the word-1 read RdCount=4.
REQ-039 Bench SHALL cover: BACT dropped during CAPTURE -> no DoutOE, no RdAck, RdCount unchanged, Changed unchanged.
REQ-040 Bench SHALL cover: a settings change on the same cycle as a word-0 capture -> Changed=1 afterward.
REQ-041 Bench SHALL cover: POR pulsed while in HOLD -> DoutOE=0 and RdAck=0 asynchronously, and RdCount=0.
REQ-042 Bench SHALL cover: RdCount preloaded by 65535 reads, then one more read -> wraps to 0.

Source files
------------

// File: rtl/settings_readback.sv
// Settings register readback: snapshots the live settings word or the
// read counter onto a 16-bit bus with a small request/acknowledge FSM.
module settings_readback (
   input  logic        CLK,
   input  logic        POR,
   input  logic        BACT,
   input  logic        SetCSRD,
   input  logic        A1,
   input  logic        SlowIACK,
   input  logic        SlowVIA,
   input  logic        SlowIWM,
   input  logic        SlowSCC,
   input  logic        SlowSCSI,
   input  logic        SlowSnd,
   input  logic        SlowClockGate,
   input  logic [3:0]  SlowTimeout,
   output logic [15:0] Dout,
   output logic        DoutOE,
   output logic        RdAck
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRIVE   = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [10:0] PREV_RST = 11'h07F;

   state_t      state_q, state_d;
   logic        rdreq_q;
   logic [15:0] dout_q, dout_d;
   logic [15:0] RdCount_q, cnt_d;
   logic        changed_q, changed_d;
   logic [10:0] prev_q;
   logic [10:0] settings;
   logic [15:0] word0;
   logic        clr;

   assign settings = {SlowTimeout, SlowIACK, SlowVIA, SlowIWM,
                      SlowSCC, SlowSCSI, SlowSnd, SlowClockGate};
   assign word0    = {4'hA, settings, changed_q};

   assign Dout   = dout_q;
   assign DoutOE = (state_q == DRIVE) || (state_q == HOLD);
   assign RdAck  = (state_q == HOLD);

   // Next-state, snapshot, counter and change-flag logic.
   always_comb begin
      state_d = state_q;
      dout_d  = '0;
      cnt_d   = RdCount_q;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rdreq_q) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (!BACT) begin
               state_d = IDLE;
            end else begin
               state_d = DRIVE;
               dout_d  = A1 ? RdCount_q : word0;
               cnt_d   = RdCount_q + 16'd1;
               clr     = !A1;
            end
         end
         DRIVE: begin
            state_d = HOLD;
            dout_d  = dout_q;
         end
         HOLD: begin
            if (!BACT) state_d = IDLE;
            else       dout_d  = dout_q;
         end
         default: state_d = IDLE;
      endcase
      // A fresh settings change outranks the clear from a word-0 read.
      if (settings != prev_q) changed_d = 1'b1;
      else if (clr)           changed_d = 1'b0;
      else                    changed_d = changed_q;
   end

   // State and datapath registers, all cleared asynchronously by POR.
   always_ff @(posedge CLK or posedge POR) begin
      if (POR) begin
         state_q   <= IDLE;
         rdreq_q   <= 1'b0;
         dout_q    <= '0;
         RdCount_q <= '0;
         changed_q <= 1'b0;
         prev_q    <= PREV_RST;
      end else begin
         state_q   <= state_d;
         rdreq_q   <= BACT && SetCSRD;
         dout_q    <= dout_d;
         RdCount_q <= cnt_d;
         changed_q <= changed_d;
         prev_q    <= settings;
      end
   end

endmodule
